// File: rtl/rv32i_types.sv
// Shared types for the memory-port arbiter: FSM states, requester ids, line width.
package rv32i_types;

   localparam int LINE_WIDTH = 256;

   typedef enum logic [2:0] {
      IDLE,
      SERVE_I,
      SERVE_D,
      RESP_I,
      RESP_D
   } arb_state_t;

   typedef enum logic {
      SRC_I,
      SRC_D
   } arb_src_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the caller owns the last_grant register.
module rr_arb2
   import rv32i_types::*;
(
   input  logic     req_i,
   input  logic     req_d,
   input  arb_src_t last_grant,
   output logic     grant_valid,
   output arb_src_t grant_src
);

   always_comb begin
      grant_valid = req_i | req_d;
      grant_src   = SRC_I;
      if (req_i && req_d) begin
         // A tie goes to whichever side did not win last time.
         grant_src = (last_grant == SRC_I) ? SRC_D : SRC_I;
      end else if (req_d) begin
         grant_src = SRC_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one cacheline-adaptor port between icache and dcache, one line
// transaction at a time, with round-robin priority and registered responses.
module mem_arbiter #(
   parameter int LINE_WIDTH = rv32i_types::LINE_WIDTH,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  i_pmem_read,
   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,

   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,

   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   import rv32i_types::*;

   arb_state_t            state_q;
   arb_src_t              last_grant_q;
   logic                  pmem_read_q;
   logic                  pmem_write_q;
   logic [ADDR_WIDTH-1:0] pmem_address_q;
   logic [LINE_WIDTH-1:0] pmem_wdata_q;
   logic [LINE_WIDTH-1:0] i_rdata_q;
   logic [LINE_WIDTH-1:0] d_rdata_q;
   logic                  i_resp_q;
   logic                  d_resp_q;

   logic                  grant_valid;
   arb_src_t              grant_src;

   rr_arb2 u_rr_arb2 (
      .req_i       (i_pmem_read),
      .req_d       (d_pmem_read | d_pmem_write),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant_src   (grant_src)
   );

   // The command registers double as the latched request: they are loaded on
   // grant and cleared on completion, so address/wdata read 0 outside SERVE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         last_grant_q   <= SRC_I;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         pmem_address_q <= '0;
         pmem_wdata_q   <= '0;
         i_rdata_q      <= '0;
         d_rdata_q      <= '0;
         i_resp_q       <= 1'b0;
         d_resp_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_valid) begin
                  last_grant_q <= grant_src;
                  if (grant_src == SRC_D) begin
                     state_q        <= SERVE_D;
                     pmem_address_q <= d_pmem_address;
                     pmem_wdata_q   <= d_pmem_wdata;
                     // Read and write together is illegal; treat it as a write.
                     pmem_write_q   <= d_pmem_write;
                     pmem_read_q    <= ~d_pmem_write;
                  end else begin
                     state_q        <= SERVE_I;
                     pmem_address_q <= i_pmem_address;
                     pmem_wdata_q   <= '0;
                     pmem_write_q   <= 1'b0;
                     pmem_read_q    <= 1'b1;
                  end
               end
            end
            SERVE_I: begin
               if (pmem_resp) begin
                  state_q        <= RESP_I;
                  i_rdata_q      <= pmem_rdata;
                  i_resp_q       <= 1'b1;
                  pmem_read_q    <= 1'b0;
                  pmem_address_q <= '0;
                  pmem_wdata_q   <= '0;
               end
            end
            SERVE_D: begin
               if (pmem_resp) begin
                  state_q <= RESP_D;
                  if (pmem_read_q) begin
                     d_rdata_q <= pmem_rdata;
                  end
                  d_resp_q       <= 1'b1;
                  pmem_read_q    <= 1'b0;
                  pmem_write_q   <= 1'b0;
                  pmem_address_q <= '0;
                  pmem_wdata_q   <= '0;
               end
            end
            RESP_I, RESP_D: begin
               state_q  <= IDLE;
               i_resp_q <= 1'b0;
               d_resp_q <= 1'b0;
            end
            default: begin
               state_q        <= IDLE;
               pmem_read_q    <= 1'b0;
               pmem_write_q   <= 1'b0;
               pmem_address_q <= '0;
               pmem_wdata_q   <= '0;
               i_resp_q       <= 1'b0;
               d_resp_q       <= 1'b0;
            end
         endcase
      end
   end

   assign pmem_read    = pmem_read_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = pmem_address_q;
   assign pmem_wdata   = pmem_wdata_q;
   assign i_pmem_rdata = i_rdata_q;
   assign i_pmem_resp  = i_resp_q;
   assign d_pmem_rdata = d_rdata_q;
   assign d_pmem_resp  = d_resp_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a hand-driven adaptor with fixed latency and
// hand-computed expected command/response values per scenario.
module tb_mem_arbiter;

   localparam int LW = 256;
   localparam int AW = 32;

   logic          clk;
   logic          rst;
   logic          i_pmem_read;
   logic [AW-1:0] i_pmem_address;
   logic [LW-1:0] i_pmem_rdata;
   logic          i_pmem_resp;
   logic          d_pmem_read;
   logic          d_pmem_write;
   logic [AW-1:0] d_pmem_address;
   logic [LW-1:0] d_pmem_wdata;
   logic [LW-1:0] d_pmem_rdata;
   logic          d_pmem_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata;
   logic          pmem_resp;

   int n_cmp  = 0;
   int n_fail = 0;

   // Observations gathered by the adaptor driver over the command cycles.
   int            n_read;
   int            n_write;
   int            resp_during;
   logic [AW-1:0] first_addr;
   logic [AW-1:0] last_addr;
   logic [LW-1:0] last_wdata;

   localparam logic [LW-1:0] RD_A5  = {32{8'hA5}};
   localparam logic [LW-1:0] RD_D1  = {8{32'hD1D1_0001}};
   localparam logic [LW-1:0] RD_I1  = {8{32'h1111_2222}};
   localparam logic [LW-1:0] RD_D2  = {8{32'hD2D2_0002}};
   localparam logic [LW-1:0] RD_I2  = {8{32'h3C3C_4B4B}};
   localparam logic [LW-1:0] WD_12  = {8{32'h1234_5678}};
   localparam logic [LW-1:0] WD_LH  = {8{32'hCAFE_F00D}};
   localparam logic [LW-1:0] JUNK   = {8{32'h5555_AAAA}};

   mem_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_address (i_pmem_address),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_address (d_pmem_address),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_rdata   (d_pmem_rdata),
      .d_pmem_resp    (d_pmem_resp),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called 1ns after an edge with the request already driven: the next edge
   // grants, the command lasts lat cycles, then we return 1ns into RESP.
   task automatic run_txn(input int lat, input logic [LW-1:0] rd, input bit mutate);
      n_read = 0;
      n_write = 0;
      resp_during = 0;
      for (int k = 1; k <= lat; k++) begin
         tick();
         if (pmem_read) n_read++;
         if (pmem_write) n_write++;
         if (i_pmem_resp || d_pmem_resp) resp_during++;
         if (k == 1) first_addr = pmem_address;
         last_addr  = pmem_address;
         last_wdata = pmem_wdata;
         if (mutate && k == 1) begin
            d_pmem_address = 32'hDEAD_BEEF;
            d_pmem_wdata   = JUNK;
            i_pmem_address = 32'h0BAD_0BAD;
         end
         if (k == lat) begin
            pmem_resp  = 1'b1;
            pmem_rdata = rd;
         end
      end
      tick();
      pmem_resp  = 1'b0;
      pmem_rdata = JUNK;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      i_pmem_read = 1'b0; i_pmem_address = '0;
      d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
      pmem_rdata = '0; pmem_resp = 1'b0;
      #1 rst = 1'b1;
      #2;
      n_cmp++; if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL reset_pmem_read: got %b want 0", pmem_read); end
      n_cmp++; if (pmem_write !== 1'b0) begin n_fail++; $display("FAIL reset_pmem_write: got %b want 0", pmem_write); end
      n_cmp++; if (pmem_address !== 32'h0) begin n_fail++; $display("FAIL reset_pmem_address: got %h want 0", pmem_address); end
      n_cmp++; if (pmem_wdata !== '0) begin n_fail++; $display("FAIL reset_pmem_wdata: got %h want 0", pmem_wdata); end
      n_cmp++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin n_fail++; $display("FAIL reset_resp: got %b want 00", {i_pmem_resp, d_pmem_resp}); end
      n_cmp++; if (i_pmem_rdata !== '0) begin n_fail++; $display("FAIL reset_i_rdata: got %h want 0", i_pmem_rdata); end
      n_cmp++; if (d_pmem_rdata !== '0) begin n_fail++; $display("FAIL reset_d_rdata: got %h want 0", d_pmem_rdata); end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_i_read();
      i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1040;
      run_txn(4, RD_A5, 1'b0);
      n_cmp++; if (n_read !== 4) begin n_fail++; $display("FAIL iread_cmd_cycles: got %0d want 4", n_read); end
      n_cmp++; if (n_write !== 0) begin n_fail++; $display("FAIL iread_write_cycles: got %0d want 0", n_write); end
      n_cmp++; if (first_addr !== 32'h0000_1040) begin n_fail++; $display("FAIL iread_first_addr: got %h want 00001040", first_addr); end
      n_cmp++; if (last_addr !== 32'h0000_1040) begin n_fail++; $display("FAIL iread_last_addr: got %h want 00001040", last_addr); end
      n_cmp++; if (resp_during !== 0) begin n_fail++; $display("FAIL iread_early_resp: got %0d want 0", resp_during); end
      n_cmp++; if (i_pmem_resp !== 1'b1) begin n_fail++; $display("FAIL iread_resp: got %b want 1", i_pmem_resp); end
      n_cmp++; if (i_pmem_rdata !== RD_A5) begin n_fail++; $display("FAIL iread_rdata: got %h want %h", i_pmem_rdata, RD_A5); end
      n_cmp++; if (d_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL iread_d_resp: got %b want 0", d_pmem_resp); end
      n_cmp++; if ({pmem_read, pmem_write} !== 2'b00) begin n_fail++; $display("FAIL iread_cmd_in_resp: got %b want 00", {pmem_read, pmem_write}); end
      n_cmp++; if (pmem_address !== 32'h0) begin n_fail++; $display("FAIL iread_addr_in_resp: got %h want 0", pmem_address); end
      i_pmem_read = 1'b0;
      tick();
      n_cmp++; if (i_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL iread_resp_pulse: got %b want 0", i_pmem_resp); end
      n_cmp++; if (i_pmem_rdata !== RD_A5) begin n_fail++; $display("FAIL iread_rdata_hold: got %h want %h", i_pmem_rdata, RD_A5); end
   endtask

   // Both sides request continuously: D wins the first tie after reset,
   // I the next, then D alone.
   task automatic test_tie();
      rst = 1'b1;
      #2 rst = 1'b0;
      i_pmem_read = 1'b1; i_pmem_address = 32'h0000_2000;
      d_pmem_read = 1'b1; d_pmem_address = 32'h0000_3000;
      run_txn(2, RD_D1, 1'b0);
      n_cmp++; if (first_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL tie1_addr: got %h want 00003000", first_addr); end
      n_cmp++; if (n_read !== 2) begin n_fail++; $display("FAIL tie1_cmd_cycles: got %0d want 2", n_read); end
      n_cmp++; if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin n_fail++; $display("FAIL tie1_resp: got %b want 01", {i_pmem_resp, d_pmem_resp}); end
      n_cmp++; if (d_pmem_rdata !== RD_D1) begin n_fail++; $display("FAIL tie1_d_rdata: got %h want %h", d_pmem_rdata, RD_D1); end
      d_pmem_address = 32'h0000_3040;
      tick();
      run_txn(2, RD_I1, 1'b0);
      n_cmp++; if (first_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL tie2_addr: got %h want 00002000", first_addr); end
      n_cmp++; if ({i_pmem_resp, d_pmem_resp} !== 2'b10) begin n_fail++; $display("FAIL tie2_resp: got %b want 10", {i_pmem_resp, d_pmem_resp}); end
      n_cmp++; if (i_pmem_rdata !== RD_I1) begin n_fail++; $display("FAIL tie2_i_rdata: got %h want %h", i_pmem_rdata, RD_I1); end
      n_cmp++; if (d_pmem_rdata !== RD_D1) begin n_fail++; $display("FAIL tie2_d_rdata_hold: got %h want %h", d_pmem_rdata, RD_D1); end
      i_pmem_read = 1'b0;
      tick();
      run_txn(1, RD_D2, 1'b0);
      n_cmp++; if (first_addr !== 32'h0000_3040) begin n_fail++; $display("FAIL tie3_addr: got %h want 00003040", first_addr); end
      n_cmp++; if (d_pmem_rdata !== RD_D2) begin n_fail++; $display("FAIL tie3_d_rdata: got %h want %h", d_pmem_rdata, RD_D2); end
      d_pmem_read = 1'b0;
      tick();
   endtask

   task automatic test_d_write();
      d_pmem_write = 1'b1; d_pmem_address = 32'h8000_0020; d_pmem_wdata = WD_12;
      run_txn(3, JUNK, 1'b0);
      n_cmp++; if (n_write !== 3) begin n_fail++; $display("FAIL dwr_cmd_cycles: got %0d want 3", n_write); end
      n_cmp++; if (n_read !== 0) begin n_fail++; $display("FAIL dwr_read_cycles: got %0d want 0", n_read); end
      n_cmp++; if (first_addr !== 32'h8000_0020) begin n_fail++; $display("FAIL dwr_addr: got %h want 80000020", first_addr); end
      n_cmp++; if (last_wdata !== WD_12) begin n_fail++; $display("FAIL dwr_wdata: got %h want %h", last_wdata, WD_12); end
      n_cmp++; if (d_pmem_resp !== 1'b1) begin n_fail++; $display("FAIL dwr_resp: got %b want 1", d_pmem_resp); end
      n_cmp++; if (d_pmem_rdata !== RD_D2) begin n_fail++; $display("FAIL dwr_rdata_unchanged: got %h want %h", d_pmem_rdata, RD_D2); end
      n_cmp++; if (pmem_wdata !== '0) begin n_fail++; $display("FAIL dwr_wdata_in_resp: got %h want 0", pmem_wdata); end
      d_pmem_write = 1'b0;
      tick();
      n_cmp++; if (d_pmem_resp !== 1'b0) begin n_fail++; $display("FAIL dwr_resp_pulse: got %b want 0", d_pmem_resp); end
   endtask

   task automatic test_latch_hold();
      d_pmem_write = 1'b1; d_pmem_address = 32'h4000_0100; d_pmem_wdata = WD_LH;
      run_txn(4, JUNK, 1'b1);
      n_cmp++; if (last_addr !== 32'h4000_0100) begin n_fail++; $display("FAIL hold_addr: got %h want 40000100", last_addr); end
      n_cmp++; if (last_wdata !== WD_LH) begin n_fail++; $display("FAIL hold_wdata: got %h want %h", last_wdata, WD_LH); end
      n_cmp++; if (n_write !== 4) begin n_fail++; $display("FAIL hold_cmd_cycles: got %0d want 4", n_write); end
      d_pmem_write = 1'b0;
      tick();
   endtask

   task automatic test_rw_both();
      d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0800; d_pmem_wdata = WD_12;
      run_txn(2, JUNK, 1'b0);
      n_cmp++; if (n_write !== 2) begin n_fail++; $display("FAIL rw_write_cycles: got %0d want 2", n_write); end
      n_cmp++; if (n_read !== 0) begin n_fail++; $display("FAIL rw_read_cycles: got %0d want 0", n_read); end
      n_cmp++; if (d_pmem_rdata !== RD_D2) begin n_fail++; $display("FAIL rw_rdata_unchanged: got %h want %h", d_pmem_rdata, RD_D2); end
      d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      d_pmem_write = 1'b1; d_pmem_address = 32'h9000_0040; d_pmem_wdata = WD_LH;
      tick();
      tick();
      n_cmp++; if (pmem_write !== 1'b1) begin n_fail++; $display("FAIL rmid_serving: got %b want 1", pmem_write); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if ({pmem_read, pmem_write} !== 2'b00) begin n_fail++; $display("FAIL rmid_cmd: got %b want 00", {pmem_read, pmem_write}); end
      n_cmp++; if (pmem_address !== 32'h0) begin n_fail++; $display("FAIL rmid_addr: got %h want 0", pmem_address); end
      n_cmp++; if (pmem_wdata !== '0) begin n_fail++; $display("FAIL rmid_wdata: got %h want 0", pmem_wdata); end
      n_cmp++; if (d_pmem_rdata !== '0) begin n_fail++; $display("FAIL rmid_d_rdata: got %h want 0", d_pmem_rdata); end
      d_pmem_write = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      pmem_resp = 1'b1; pmem_rdata = JUNK;
      tick();
      pmem_resp = 1'b0;
      n_cmp++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin n_fail++; $display("FAIL rmid_late_resp: got %b want 00", {i_pmem_resp, d_pmem_resp}); end
      tick();
      n_cmp++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin n_fail++; $display("FAIL rmid_late_resp2: got %b want 00", {i_pmem_resp, d_pmem_resp}); end
      i_pmem_read = 1'b1; i_pmem_address = 32'h0000_5080;
      run_txn(3, RD_I2, 1'b0);
      n_cmp++; if (first_addr !== 32'h0000_5080) begin n_fail++; $display("FAIL rmid_i_addr: got %h want 00005080", first_addr); end
      n_cmp++; if (n_read !== 3) begin n_fail++; $display("FAIL rmid_i_cycles: got %0d want 3", n_read); end
      n_cmp++; if (i_pmem_resp !== 1'b1) begin n_fail++; $display("FAIL rmid_i_resp: got %b want 1", i_pmem_resp); end
      n_cmp++; if (i_pmem_rdata !== RD_I2) begin n_fail++; $display("FAIL rmid_i_rdata: got %h want %h", i_pmem_rdata, RD_I2); end
      i_pmem_read = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_i_read();
      test_tie();
      test_d_write();
      test_latch_hold();
      test_rw_both();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
